// File: rtl/move_cmd_parser.sv
// Streamed ASCII move-command parser: source -> count -> destination prompts, valid/ready command out.
// Optional CANCEL_EN: ESC aborts a move in progress (or clears the partial source field).
module move_cmd_parser #(
   parameter int unsigned NUM_TABLEAUS = 7,
   parameter int unsigned MAX_RUN      = 19,
   parameter int unsigned IDX_W        = 7,
   parameter int unsigned CNT_W        = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [IDX_W-1:0] cmd_source,
   output logic [CNT_W-1:0] cmd_offset,
   output logic [IDX_W-1:0] cmd_dest,
   input  logic             resp_valid,
   input  logic             resp_success,
   output logic [1:0]       prompt,
   output logic             err_pulse,
   output logic [2:0]       err_code
);

   localparam int unsigned ACC_W = 7;
   localparam logic [ACC_W-1:0] TAB_MAX = ACC_W'(NUM_TABLEAUS);
   localparam logic [ACC_W-1:0] SRC_MAX = ACC_W'(NUM_TABLEAUS + 2);
   localparam logic [ACC_W-1:0] RUN_MAX = ACC_W'(MAX_RUN);

   localparam logic [7:0] CH_LF  = 8'd10;
   localparam logic [7:0] CH_CR  = 8'd13;
   localparam logic [7:0] CH_ESC = 8'd27;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;

   typedef enum logic [2:0] {
      S_SRC,
      S_CNT,
      S_DST,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t           state, state_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [1:0]       ndig, ndig_n;
   logic             bad, bad_n;
   logic             too_long, too_long_n;
   logic             rx_ready_n;
   logic [IDX_W-1:0] src_n, dst_n;
   logic [CNT_W-1:0] off_n;
   logic             err_pulse_n;
   logic [2:0]       err_code_n;

   logic             take;
   logic             is_digit;
   logic             in_range;
   logic             src_tab;
   logic [ACC_W-1:0] acc_dig;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_SRC;
         acc        <= '0;
         ndig       <= '0;
         bad        <= 1'b0;
         too_long   <= 1'b0;
         rx_ready   <= 1'b0;
         cmd_source <= '0;
         cmd_offset <= '0;
         cmd_dest   <= '0;
         err_pulse  <= 1'b0;
         err_code   <= '0;
      end else begin
         state      <= state_n;
         acc        <= acc_n;
         ndig       <= ndig_n;
         bad        <= bad_n;
         too_long   <= too_long_n;
         rx_ready   <= rx_ready_n;
         cmd_source <= src_n;
         cmd_offset <= off_n;
         cmd_dest   <= dst_n;
         err_pulse  <= err_pulse_n;
         err_code   <= err_code_n;
      end
   end

   always_comb begin
      cmd_valid = (state == S_ISSUE);
      case (state)
         S_SRC:   prompt = 2'd0;
         S_CNT:   prompt = 2'd1;
         S_DST:   prompt = 2'd2;
         default: prompt = 2'd3;
      endcase
   end

   always_comb begin
      take     = rx_valid & rx_ready;
      is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
      // At most two digits are ever accumulated, so acc*10+digit stays below 100.
      acc_dig  = (acc << 3) + (acc << 1) + {3'b000, rx_data[3:0]};
      src_tab  = (cmd_source != '0) && (cmd_source <= IDX_W'(TAB_MAX));
      in_range = 1'b0;
      case (state)
         S_SRC:   in_range = (acc <= SRC_MAX);
         S_CNT:   in_range = (acc != '0) && (acc <= RUN_MAX);
         S_DST:   in_range = (acc <= TAB_MAX);
         default: in_range = 1'b0;
      endcase

      state_n     = state;
      acc_n       = acc;
      ndig_n      = ndig;
      bad_n       = bad;
      too_long_n  = too_long;
      src_n       = cmd_source;
      off_n       = cmd_offset;
      dst_n       = cmd_dest;
      err_pulse_n = 1'b0;
      err_code_n  = err_code;

      case (state)
         S_SRC, S_CNT, S_DST: begin
            if (take) begin
               if (rx_data == CH_LF) begin
                  acc_n      = '0;
                  ndig_n     = '0;
                  bad_n      = 1'b0;
                  too_long_n = 1'b0;
                  if (bad) begin
                     err_pulse_n = 1'b1;
                     err_code_n  = 3'd1;
                  end else if ((ndig == 2'd0) || too_long) begin
                     err_pulse_n = 1'b1;
                     err_code_n  = 3'd2;
                  end else if (!in_range) begin
                     err_pulse_n = 1'b1;
                     err_code_n  = 3'd3;
                  end else if ((state == S_DST) && src_tab && (IDX_W'(acc) == cmd_source)) begin
                     err_pulse_n = 1'b1;
                     err_code_n  = 3'd4;
                  end else begin
                     case (state)
                        S_SRC: begin
                           src_n = IDX_W'(acc);
                           if (acc == '0) begin
                              off_n   = '0;
                              state_n = S_DST;
                           end else if (acc <= TAB_MAX) begin
                              state_n = S_CNT;
                           end else begin
                              off_n   = '0;
                              dst_n   = '0;
                              state_n = S_ISSUE;
                           end
                        end
                        S_CNT: begin
                           off_n   = CNT_W'(acc - 7'd1);
                           state_n = S_DST;
                        end
                        default: begin
                           dst_n   = IDX_W'(acc);
                           state_n = S_ISSUE;
                        end
                     endcase
                  end
               end else if (rx_data == CH_CR) begin
                  acc_n = acc;
               end else if (is_digit) begin
                  if (ndig == 2'd2) begin
                     too_long_n = 1'b1;
                  end else begin
                     acc_n  = acc_dig;
                     ndig_n = ndig + 2'd1;
                  end
`ifdef CANCEL_EN
               end else if (rx_data == CH_ESC) begin
                  acc_n      = '0;
                  ndig_n     = '0;
                  bad_n      = 1'b0;
                  too_long_n = 1'b0;
                  if (state != S_SRC) begin
                     src_n       = '0;
                     off_n       = '0;
                     dst_n       = '0;
                     err_pulse_n = 1'b1;
                     err_code_n  = 3'd6;
                     state_n     = S_SRC;
                  end
`endif
               end else begin
                  bad_n = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (cmd_ready) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (resp_valid) begin
               state_n = S_SRC;
               if (!resp_success) begin
                  err_pulse_n = 1'b1;
                  err_code_n  = 3'd5;
               end
            end
         end
         default: state_n = S_SRC;
      endcase

      rx_ready_n = (state_n == S_SRC) || (state_n == S_CNT) || (state_n == S_DST);
   end

   // ESC is only special with CANCEL_EN; keep the constant referenced in both builds.
   logic unused_esc;
   assign unused_esc = ^CH_ESC;

endmodule

// File: doc/move_cmd_parser.md
Name: move_cmd_parser

Overview:
- Synthesizable replacement for the blocking console-read front end of the solitaire game; turns a streamed ASCII byte channel into validated move commands for the game engine.
- Parametrised in tableau count and run length; accepts multi-digit decimal fields, so runs of 10 or more cards are legal.
- Runs a source → count → destination prompt sequence, rejects malformed fields locally, issues one command per move over a valid/ready handshake, and waits for the engine's success/fail response.

Parameters:
- NUM_TABLEAUS, 7, number of tableau piles. Legal range 1..97.
- MAX_RUN, 19, maximum number of cards movable from one tableau. Equals the tableau depth.
- IDX_W, 7, width of the source and destination index fields.
- CNT_W, 5, width of the offset field.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  ASCII character
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  parser accepts a character this cycle
- cmd_valid  out  1  move command valid
- cmd_ready  in  1  engine accepts the command
- cmd_source  out  IDX_W  source code
- cmd_offset  out  CNT_W  number of cards minus 1
- cmd_dest  out  IDX_W  destination code
- resp_valid  in  1  engine response strobe
- resp_success  in  1  move was legal and applied; qualified by resp_valid
- prompt  out  2  which prompt to display: 0 source, 1 count, 2 destination, 3 busy
- err_pulse  out  1  one-cycle error strobe
- err_code  out  3  error code, held until the next err_pulse

Behaviour:
- Reset values: rx_ready=0, cmd_valid=0, cmd_source/cmd_offset/cmd_dest=0, prompt=0, err_pulse=0, err_code=0, state=S_SRC, field accumulator cleared.
- rx_ready is registered. It rises 1 clk after reset release.
- rx_ready=1 only in S_SRC, S_CNT and S_DST. A character is taken on rx_valid & rx_ready.
- Source codes: 0 talon; 1..N tableau; N+1 draw from stock; N+2 auto-move.
- Destination codes: 0 foundation; 1..N tableau.
- Field lexing:
  - '0'-'9' accumulate acc = acc*10 + digit.
  - CR (13) is ignored.
  - LF (10) terminates the field.
  - Any other character sets a sticky bad flag.
  - A third digit sets a sticky too-long flag.
- Field checks at LF, in priority order:
  - bad flag → err_code 1.
  - Empty field or too-long flag → err_code 2.
  - Out of range → err_code 3.
  - On any reject: err_pulse for 1 cycle, clear acc and flags, stay in the current state.
- S_SRC, on a valid LF:
  - Latch cmd_source.
  - Tableau source → S_CNT.
  - Talon source → offset=0, go to S_DST.
  - Draw or auto source → offset=0, dest=0, go to S_ISSUE.
- S_CNT: legal range 1..MAX_RUN. On a valid LF, cmd_offset = value-1, then → S_DST.
- S_DST:
  - Legal range 0..N.
  - If the source is a tableau and dest == source → err_code 4, stay in S_DST.
  - On a valid LF → S_ISSUE.
- S_ISSUE:
  - cmd_valid=1; cmd_* held stable until cmd_valid & cmd_ready.
  - The handshake cycle completes the transfer. Next cycle cmd_valid=0, state=S_WAIT.
- S_WAIT:
  - On resp_valid: success → S_SRC.
  - On resp_valid: fail → err_pulse, err_code 5, S_SRC.
  - resp_valid outside S_WAIT is ignored.
- prompt follows the state: S_SRC=0, S_CNT=1, S_DST=2, S_ISSUE/S_WAIT=3.
- Minimum latency: 1 clk from the accepted LF of the last field to cmd_valid=1.
- Reset asserted mid-sequence aborts immediately: outputs return to reset values and any pending command is dropped.
- Holding rx_valid high across many cycles consumes one character per cycle in the input states.

Optional Feature:
- Macro CANCEL_EN.
- Defined:
  - ESC (27) received in S_CNT or S_DST aborts the move: cmd fields cleared, acc cleared, err_pulse, err_code 6, → S_SRC.
  - ESC in S_SRC only clears the partial field, with no error.
- Undefined: ESC is an ordinary invalid character (sticky bad flag → err_code 1 at LF).

Test Plan:
- Stream "3\n2\n5\n" with N=7, cmd_ready=1 → cmd_valid with source 3, offset 1, dest 5; prompt sequence 0,1,2,3; then resp_valid=1, resp_success=1 → prompt 0.
- Stream "4\n13\n0\n" → offset 12, dest 0. This checks two-digit counts.
- Stream "12\n", "\n" and "5x\n" in S_SRC → err_code 3, 2 and 1 respectively; the parser stays in S_SRC each time.
- Stream "8\n" → command issued immediately with source 8, offset 0, dest 0. Hold cmd_ready=0 for 5 cycles → fields stable and cmd_valid held until cmd_ready.
- Stream "2\n1\n2\n" → err_code 4 after the third field, still in S_DST. Then "6\n" → command with dest 6; resp_success=0 → err_code 5.
- With CANCEL_EN, stream "3\n" then ESC → err_code 6, prompt 0. Assert rst low while in S_WAIT → all outputs return to reset values asynchronously.
